noc_output_arbiter: RTL and testbench

- Per-output-port switch allocator for the NoC router.
- Drives the 5-bit one-hot grant that selects which input port feeds one output port's flit mux and FIFO.
- Round-robin arbitration with wormhole packet locking: a grant is taken on a header flit and held until that packet's tail flit is accepted.
- A watchdog flags a locked owner that stops delivering flits.

---
 rtl/noc_output_arbiter_pkg.sv | 12 +
 rtl/noc_output_arbiter_rr_pick.sv | 37 +++
 rtl/noc_output_arbiter.sv | 115 +++++++++++
 tb/tb_noc_output_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_output_arbiter_pkg.sv
// Shared parameters and types for the NoC output-port switch allocator.
package noc_output_arbiter_pkg;

    localparam int Noc_Port_Num     = 5;
    localparam int Noc_Arb_Watchdog = 1024;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/noc_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module noc_rr_pick
    import noc_output_arbiter_pkg::*;
#(
    parameter int N     = Noc_Port_Num,
    parameter int IDX_W = $clog2(Noc_Port_Num)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;
    logic           w_hit;

    assign w_dbl     = {req, req};
    assign gnt_valid = |req;

    // Mask off the lower copy below ptr; the upper copy supplies the wrap-around candidates.
    always_comb begin
        w_masked = '0;
        gnt_idx  = '0;
        w_hit    = 1'b0;
        for (int unsigned j = 0; j < 2 * N; j++) begin
            w_masked[j] = w_dbl[j] && (j >= 32'(ptr));
        end
        for (int unsigned j = 0; j < 2 * N; j++) begin
            if (!w_hit && w_masked[j]) begin
                w_hit   = 1'b1;
                gnt_idx = IDX_W'(j % N);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port wormhole switch allocator: round-robin pick, packet lock, stall watchdog.
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int N_PORTS         = Noc_Port_Num,
    parameter int WATCHDOG_CYCLES = Noc_Arb_Watchdog
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic [N_PORTS-1:0]         i_req,
    input  logic [N_PORTS-1:0]         i_tail,
    input  logic                       i_xfer,
    input  logic                       i_clear,
    output logic [N_PORTS-1:0]         o_grant,
    output logic                       o_locked,
    output logic [$clog2(N_PORTS)-1:0] o_owner,
    output logic                       o_stall_err
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [N_PORTS-1:0] r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_stall_err;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_release;

    noc_rr_pick #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (i_req),
        .ptr       (r_rr_ptr),
        .gnt_idx   (w_pick_idx),
        .gnt_valid (w_pick_valid)
    );

    // FSM state register.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: lock on any request in IDLE, release on the owner's accepted tail flit.
    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (i_xfer && i_tail[r_owner]) begin
                    w_release   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Grant, owner and round-robin pointer registers.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_pick_valid) begin
                r_owner <= w_pick_idx;
                r_grant <= N_PORTS'(1) << w_pick_idx;
            end
        end else if (w_release) begin
            r_grant  <= '0;
            r_rr_ptr <= (r_owner == LAST_PORT) ? '0 : r_owner + 1'b1;
        end
    end

    // Watchdog: counts locked cycles without a transfer; the error is sticky until cleared.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_wd_cnt    <= '0;
            r_stall_err <= 1'b0;
        end else if (i_clear) begin
            r_wd_cnt    <= '0;
            r_stall_err <= 1'b0;
        end else if (r_state != ARB_LOCKED || i_xfer) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if (r_wd_cnt == WD_MAX - 1'b1) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_locked    = (r_state == ARB_LOCKED);
    assign o_owner     = r_owner;
    assign o_stall_err = r_stall_err;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter with a queue-free arithmetic reference model.
module tb_noc_output_arbiter;

    localparam int N  = 5;
    localparam int WD = 8;

    logic       noc_clk;
    logic       noc_rst_n;
    logic [4:0] i_req;
    logic [4:0] i_tail;
    logic       i_xfer;
    logic       i_clear;
    logic [4:0] o_grant;
    logic       o_locked;
    logic [2:0] o_owner;
    logic       o_stall_err;

    noc_output_arbiter #(
        .N_PORTS         (N),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .noc_clk     (noc_clk),
        .noc_rst_n   (noc_rst_n),
        .i_req       (i_req),
        .i_tail      (i_tail),
        .i_xfer      (i_xfer),
        .i_clear     (i_clear),
        .o_grant     (o_grant),
        .o_locked    (o_locked),
        .o_owner     (o_owner),
        .o_stall_err (o_stall_err)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [4:0] grant;
        bit         locked;
        int         owner;
        bit         err;
    } exp_t;

    exp_t sb[$];
    bit   mon_en = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    // Reference model state: who owns the output, where the next search starts, stall bookkeeping.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_wd;
    bit m_err;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_wd     = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] req, input logic [4:0] tail, input bit xfer, input bit clr);
        bit set_err;
        set_err = 1'b0;
        if (!m_locked) begin
            m_wd = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (req[p]) begin
                    m_owner  = p;
                    m_locked = 1'b1;
                    break;
                end
            end
        end else if (xfer && tail[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
            m_wd     = 0;
        end else if (xfer) begin
            m_wd = 0;
        end else if (m_wd < WD) begin
            m_wd++;
            if (m_wd == WD) set_err = 1'b1;
        end
        if (clr) begin
            m_wd  = 0;
            m_err = 1'b0;
        end else if (set_err) begin
            m_err = 1'b1;
        end
    endtask

    // One clock of stimulus; the expectation for the following cycle goes to the scoreboard.
    task automatic cycle(input logic [4:0] req, input logic [4:0] tail, input bit xfer, input bit clr);
        exp_t e;
        i_req   = req;
        i_tail  = tail;
        i_xfer  = xfer;
        i_clear = clr;
        model_step(req, tail, xfer, clr);
        e.grant  = m_locked ? 5'(1 << m_owner) : 5'd0;
        e.locked = m_locked;
        e.owner  = m_owner;
        e.err    = m_err;
        @(posedge noc_clk);
        #1;
        sb.push_back(e);
    endtask

    // Monitor: compares DUT outputs against the oldest expectation on each falling edge.
    always @(negedge noc_clk) begin
        if (mon_en && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("grant", int'(o_grant), int'(e.grant));
            check("locked", int'(o_locked), int'(e.locked));
            if (e.locked) check("owner", int'(o_owner), e.owner);
            check("stall_err", int'(o_stall_err), int'(e.err));
        end
    end

    initial begin
        int pct;
        noc_rst_n = 1'b0;
        i_req     = '0;
        i_tail    = '0;
        i_xfer    = 1'b0;
        i_clear   = 1'b0;
        model_reset();

        @(posedge noc_clk);
        #1;
        check("rst_grant", int'(o_grant), 0);
        check("rst_locked", int'(o_locked), 0);
        check("rst_owner", int'(o_owner), 0);
        check("rst_err", int'(o_stall_err), 0);
        noc_rst_n = 1'b1;
        mon_en    = 1'b1;

        // Single requester, four-flit packet; then pointer must favour port 3 over port 2.
        cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        repeat (3) cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00100, 5'b00100, 1'b1, 1'b0);
        cycle(5'b01100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b01100, 5'b01000, 1'b1, 1'b0);
        cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

        // Round-robin fairness with all ports requesting two-flit packets.
        repeat (6) begin
            cycle(5'b11111, 5'b00000, 1'b0, 1'b0);
            cycle(5'b11111, 5'b00000, 1'b1, 1'b0);
            cycle(5'b11111, 5'b11111, 1'b1, 1'b0);
        end

        // Lock hold on owner 1: other requests and non-owner tails are ignored.
        cycle(5'b00010, 5'b00000, 1'b0, 1'b0);
        repeat (10) cycle(5'b11111, 5'b11111, 1'b0, 1'b0);
        cycle(5'b11111, 5'b11101, 1'b1, 1'b0);
        cycle(5'b11111, 5'b00010, 1'b1, 1'b0);
        cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

        // Single-flit packet from port 4, then the pointer wraps to 0.
        cycle(5'b10000, 5'b10000, 1'b0, 1'b0);
        cycle(5'b10000, 5'b10000, 1'b1, 1'b0);
        cycle(5'b00011, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00011, 5'b00011, 1'b1, 1'b0);
        cycle(5'b00000, 5'b00000, 1'b1, 1'b0);

        // Watchdog: stall to error, clear, restart on xfer at cycle 7, clear colliding with saturation.
        cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        repeat (10) cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b1, 1'b1);
        repeat (6) cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        repeat (7) cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        repeat (7) cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b0, 1'b1);
        repeat (3) cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00100, 1'b1, 1'b0);
        cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

        // Randomised traffic with varying downstream acceptance rates.
        pct = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 5;
                    1:       pct = 50;
                    default: pct = 90;
                endcase
            end
            cycle(5'($urandom), 5'($urandom),
                  ($urandom_range(0, 99) < pct), ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset while a packet owns the output.
        cycle(5'b01000, 5'b00000, 1'b0, 1'b0);
        cycle(5'b11111, 5'b00000, 1'b1, 1'b0);
        mon_en = 1'b0;
        sb.delete();
        #2;
        noc_rst_n = 1'b0;
        #1;
        check("async_rst_grant", int'(o_grant), 0);
        check("async_rst_locked", int'(o_locked), 0);
        check("async_rst_owner", int'(o_owner), 0);
        model_reset();
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        mon_en    = 1'b1;
        cycle(5'b11111, 5'b00000, 1'b0, 1'b0);
        cycle(5'b11111, 5'b11111, 1'b1, 1'b0);
        cycle(5'b11111, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00000, 5'b11111, 1'b1, 1'b0);
        cycle(5'b00000, 5'b00000, 1'b0, 1'b0);

        @(negedge noc_clk);
        #1;
        if (sb.size() != 0) begin
            check("sb_drain", sb.size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
